// File: rtl/riscv_if_aligner.sv
// riscv_if_aligner: fetch-word buffer and RV32C-aware instruction aligner.
// Word-aligned 32-bit fetch words are stored in a small circular FIFO. Each
// output handshake emits one instruction with its halfword-aligned PC. That
// instruction is 16 bits, or 32 bits that may straddle two words. A branch
// flushes the buffer and restarts alignment at any halfword.
//
// Handshake rule for both ports: a transfer happens on a rising edge where
// valid and ready are both high. While valid is high and ready is low, the
// producer holds its payload stable. The producer does not drop valid, except
// when a branch or a reset discards the payload.
module riscv_if_aligner #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_rdata_i,
    input  logic             in_err_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_instr_o,
    output logic             out_is_compressed_o,
    output logic [31:0]      out_pc_o,
    output logic             out_err_o,
    output logic [CNT_W-1:0] count_o,
    output logic             dbg_state_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    // ALIGNED: next instruction starts at head[15:0];
    // MISALIGNED: next instruction starts at head[31:16].
    typedef enum logic {
        ST_ALIGNED    = 1'b0,
        ST_MISALIGNED = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_mem_data [DEPTH];
    logic             r_mem_err  [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_pc;

    logic [PTR_W-1:0] w_next_ptr;
    logic [31:0]      w_head_data;
    logic             w_head_err;
    logic [31:0]      w_next_data;
    logic             w_next_err;
    logic             w_has1;
    logic             w_has2;
    logic             w_valid;
    logic [31:0]      w_instr;
    logic             w_compr;
    logic             w_err;
    logic             w_pop_req;
    logic             w_hs;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pc_inc;

    // Head and head+1 views of the FIFO; the pointer wraps naturally at DEPTH.
    always_comb begin
        w_next_ptr  = r_rd_ptr + 1'b1;
        w_head_data = r_mem_data[r_rd_ptr];
        w_head_err  = r_mem_err[r_rd_ptr];
        w_next_data = r_mem_data[w_next_ptr];
        w_next_err  = r_mem_err[w_next_ptr];
        w_has1      = (r_count != '0);
        w_has2      = (r_count >= CNT_TWO);
    end

    // Alignment decode: the output instruction, its validity, whether it pops, and the next state.
    always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        w_instr      = 32'h0;
        w_compr      = 1'b0;
        w_err        = 1'b0;
        w_pop_req    = 1'b0;
        case (r_state)
            ST_ALIGNED: begin
                if (w_has1) begin
                    w_valid = 1'b1;
                    w_err   = w_head_err;
                    if (w_head_data[1:0] != 2'b11) begin
                        // Upper half of this word still holds the next parcel.
                        w_instr = {16'h0, w_head_data[15:0]};
                        w_compr = 1'b1;
                        if (out_ready_i) w_state_next = ST_MISALIGNED;
                    end else begin
                        w_instr   = w_head_data;
                        w_pop_req = 1'b1;
                    end
                end
            end
            ST_MISALIGNED: begin
                if (w_head_data[17:16] != 2'b11) begin
                    if (w_has1) begin
                        w_valid   = 1'b1;
                        w_instr   = {16'h0, w_head_data[31:16]};
                        w_compr   = 1'b1;
                        w_err     = w_head_err;
                        w_pop_req = 1'b1;
                        if (out_ready_i) w_state_next = ST_ALIGNED;
                    end
                end else if (w_has2) begin
                    w_valid   = 1'b1;
                    w_instr   = {w_next_data[15:0], w_head_data[31:16]};
                    w_err     = w_head_err | w_next_err;
                    w_pop_req = 1'b1;
                end else if (w_has1 && w_head_err) begin
                    // A faulting first half cannot be completed; report it now.
                    w_valid   = 1'b1;
                    w_instr   = {16'h0, w_head_data[31:16]};
                    w_err     = 1'b1;
                    w_pop_req = 1'b1;
                end
            end
            default: w_state_next = ST_ALIGNED;
        endcase
    end

    // Handshake qualifiers; a branch discards any push or pop offered with it.
    always_comb begin
        in_ready_o = ~rst & (r_count < CNT_FULL);
        w_hs       = w_valid & out_ready_i & ~branch_i;
        w_push     = in_valid_i & in_ready_o & ~branch_i;
        w_pop      = w_hs & w_pop_req;
        w_pc_inc   = w_compr ? 32'd2 : 32'd4;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ALIGNED;
        end else if (branch_i) begin
            r_state <= branch_addr_i[1] ? ST_MISALIGNED : ST_ALIGNED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO pointers, occupancy, and PC tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_pc     <= RESET_PC;
        end else if (branch_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_pc     <= {branch_addr_i[31:1], 1'b0};
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_hs) r_pc <= r_pc + w_pc_inc;
        end
    end

    // FIFO storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_rdata_i;
            r_mem_err[r_wr_ptr]  <= in_err_i;
        end
    end

    // Output drive.
    always_comb begin
        out_valid_o         = w_valid;
        out_instr_o         = w_instr;
        out_is_compressed_o = w_compr;
        out_err_o           = w_err;
        out_pc_o            = r_pc;
        count_o             = r_count;
        dbg_state_o         = r_state;
    end

endmodule
